// File: rtl/cordic_range_reducer.sv
//------------------------------------------------------------------------------
// cordic_range_reducer
//
// Purpose:
//   Front end for a CORDIC rotation core that only converges for angles in
//   [-pi/2, pi/2).  A full-circle phase in turn units is folded into that half
//   circle by subtracting pi when it lies in the left half plane.  The folded
//   phase is converted to Q1.14 radians and handed to the core.  The core's
//   cos/sin results are negated on the way out to undo the fold, because
//   cos(x + pi) = -cos(x) and sin(x + pi) = -sin(x).
//   One transaction is in flight at a time:
//   IDLE -> ISSUE -> WAIT -> OUT -> IDLE.
//
// Configuration macro:
//   CORDIC_RR_ROUND_EN - when defined, the phase-to-radian conversion rounds
//                        half up instead of truncating.
//
// Parameters:
//   WL - word length of angle/cos/sin values (default 16)
//   FL - fractional bits of the Q1.FL values (default 14)
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   asynchronous active-high reset
//   in_valid     in   phase_in is valid
//   in_ready     out  block accepts phase_in (high only in IDLE)
//   phase_in     in   16-bit two's-complement turn units (0x4000 = pi/2)
//   cordic_start out  one-cycle start request to the CORDIC core
//   cordic_angle out  reduced angle, Q1.14 radians, [-pi/2, pi/2)
//   cordic_done  in   CORDIC completion flag (rising edge completes WAIT)
//   cordic_cos   in   CORDIC cosine result, Q1.14
//   cordic_sin   in   CORDIC sine result, Q1.14
//   out_valid    out  cos_out/sin_out valid, held until out_ready
//   out_ready    in   consumer accepts the result
//   cos_out      out  full-circle cosine, Q1.14
//   sin_out      out  full-circle sine, Q1.14
//------------------------------------------------------------------------------
module cordic_range_reducer #(
    parameter int WL = 16,
    parameter int FL = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          phase_in,
    output logic                 cordic_start,
    output logic signed [WL-1:0] cordic_angle,
    input  logic                 cordic_done,
    input  logic signed [WL-1:0] cordic_cos,
    input  logic signed [WL-1:0] cordic_sin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [WL-1:0] cos_out,
    output logic signed [WL-1:0] sin_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // pi/2 in Q1.14; one quarter turn (0x4000) maps to this many LSBs.
    localparam logic signed [31:0] HALF_PI_Q = 32'sd25736;

`ifdef CORDIC_RR_ROUND_EN
    localparam logic signed [31:0] ROUND_ADD = 32'sd1 <<< (FL - 1);
`else
    localparam logic signed [31:0] ROUND_ADD = 32'sd0;
`endif

    localparam logic signed [WL-1:0] MOST_NEG = {1'b1, {(WL-1){1'b0}}};
    localparam logic signed [WL-1:0] MOST_POS = {1'b0, {(WL-1){1'b1}}};

    // Negation that clamps the single non-negatable code to the largest
    // positive value instead of wrapping back to itself.
    function automatic logic signed [WL-1:0] neg_sat(input logic signed [WL-1:0] v);
        logic signed [WL-1:0] res;
        if (v == MOST_NEG) begin
            res = MOST_POS;
        end else begin
            res = -v;
        end
        return res;
    endfunction

    state_t r_state;
    logic   r_flip;
    logic   r_done_q;

    logic                 w_fold;
    logic signed [15:0]   w_p;
    logic signed [31:0]   w_p_ext;
    logic signed [31:0]   w_prod;
    logic signed [WL-1:0] w_angle;
    logic                 w_done_rise;

    // The two top bits differ exactly in the left half plane (quadrants 1, 2);
    // flipping bit 15 there adds pi modulo the full turn.
    assign w_fold      = phase_in[15] ^ phase_in[14];
    assign w_p         = {phase_in[15] ^ w_fold, phase_in[14:0]};
    assign w_p_ext     = 32'(w_p);
    assign w_prod      = (w_p_ext * HALF_PI_Q) + ROUND_ADD;
    assign w_angle     = WL'(w_prod >>> FL);
    // r_done_q tracks cordic_done every cycle, so a level already high when
    // WAIT is entered never looks like an edge.
    assign w_done_rise = cordic_done & ~r_done_q;

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            in_ready     <= 1'b1;
            cordic_start <= 1'b0;
            out_valid    <= 1'b0;
            cordic_angle <= '0;
            cos_out      <= '0;
            sin_out      <= '0;
            r_flip       <= 1'b0;
            r_done_q     <= 1'b0;
        end else begin
            r_done_q <= cordic_done;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        cordic_angle <= w_angle;
                        r_flip       <= w_fold;
                        cordic_start <= 1'b1;
                        in_ready     <= 1'b0;
                        r_state      <= ST_ISSUE;
                    end else begin
                        r_state      <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    cordic_start <= 1'b0;
                    r_state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_done_rise) begin
                        if (r_flip) begin
                            cos_out <= neg_sat(cordic_cos);
                            sin_out <= neg_sat(cordic_sin);
                        end else begin
                            cos_out <= cordic_cos;
                            sin_out <= cordic_sin;
                        end
                        out_valid <= 1'b1;
                        r_state   <= ST_OUT;
                    end else begin
                        r_state   <= ST_WAIT;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_state   <= ST_OUT;
                    end
                end
                default: begin
                    cordic_start <= 1'b0;
                    out_valid    <= 1'b0;
                    in_ready     <= 1'b1;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
